// File: rtl/pcm_frame_sync_pkg.sv
// pcm_frame_sync_pkg: shared state encodings, counter width, default sync
// word and helpers for the PCM frame synchronizer.
package pcm_frame_sync_pkg;

  typedef enum logic [1:0] {
    FS_SEARCH   = 2'd0,
    FS_CHECK    = 2'd1,
    FS_LOCK     = 2'd2,
    FS_FLYWHEEL = 2'd3
  } fs_state_t;

  localparam int FS_CNT_W = 16;
  localparam int FS_DEFAULT_SYNC_WIDTH = 32;
  localparam logic [31:0] FS_DEFAULT_SYNC = 32'hFE6B2840;

  // A frame must hold the whole sync word plus at least one more bit, so
  // shorter programmed lengths are raised to that minimum.
  function automatic logic [FS_CNT_W-1:0] fs_eff_length(
    input logic [FS_CNT_W-1:0] len,
    input int                  sync_width
  );
    logic [FS_CNT_W-1:0] min_len;
    min_len = FS_CNT_W'(sync_width + 1);
    return (len < min_len) ? min_len : len;
  endfunction

endpackage

// File: rtl/pcm_frame_sync_correlator.sv
// sync_correlator: shifts in the decoded bit stream and counts masked bit
// errors against a pattern. The count reflects the shift register value
// that includes the bit being presented this cycle, so the caller can act
// on it in the same clock as the bit strobe.
module sync_correlator
  import pcm_frame_sync_pkg::*;
#(
  parameter int SYNC_WIDTH = FS_DEFAULT_SYNC_WIDTH,
  parameter int ERR_W      = $clog2(SYNC_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bit_en,
  input  logic                  bit_in,
  input  logic [SYNC_WIDTH-1:0] pattern,
  input  logic [SYNC_WIDTH-1:0] mask,
  output logic [ERR_W-1:0]      errors
);

  logic [SYNC_WIDTH-1:0] sr;
  logic [SYNC_WIDTH-1:0] sr_next;
  logic [SYNC_WIDTH-1:0] diff;

  assign sr_next = {sr[SYNC_WIDTH-2:0], bit_in};

  // Shift register advances only on a bit strobe; first-received bit ends up in the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (bit_en) begin
      sr <= sr_next;
    end
  end

  // Masked popcount of the mismatch between the look-ahead window and the pattern.
  always_comb begin
    diff   = (sr_next ^ pattern) & mask;
    errors = '0;
    for (int i = 0; i < SYNC_WIDTH; i++) begin
      errors = errors + ERR_W'(diff[i]);
    end
  end

endmodule

// File: rtl/pcm_frame_sync.sv
// pcm_frame_sync: frame synchronizer for the PCM decoder bit stream.
// Correlates a programmable sync word and tracks frame position through
// SEARCH / CHECK / LOCK / FLYWHEEL.
// Optional feature macro: PCM_FRAME_SYNC_INVERT_EN adds a second correlator
// against the complemented sync word so an inverted stream can be acquired
// and its polarity corrected; without it, inverted stays 0.
module pcm_frame_sync
  import pcm_frame_sync_pkg::*;
#(
  parameter  int SYNC_WIDTH = FS_DEFAULT_SYNC_WIDTH,
  localparam int ERR_W      = $clog2(SYNC_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bitEn,
  input  logic                  bitIn,
  input  logic                  resync,
  input  logic [SYNC_WIDTH-1:0] syncPattern,
  input  logic [SYNC_WIDTH-1:0] syncMask,
  input  logic [FS_CNT_W-1:0]   frameLength,
  input  logic [3:0]            searchTol,
  input  logic [3:0]            lockTol,
  input  logic [2:0]            checkFrames,
  input  logic [2:0]            flyFrames,
  output logic                  bitOut,
  output logic                  bitEnOut,
  output logic                  frameStart,
  output logic [FS_CNT_W-1:0]   bitCount,
  output logic [1:0]            state,
  output logic                  locked,
  output logic [ERR_W-1:0]      errCount,
  output logic                  inverted
);

  fs_state_t            state_q;
  logic [2:0]           hit_cnt;
  logic [3:0]           miss_cnt;

  logic [ERR_W-1:0]     err_true;
  logic [ERR_W-1:0]     err_track;
  logic [ERR_W-1:0]     search_err;
  logic                 true_hit;
  logic                 inv_hit;
  logic                 search_hit;
  logic                 set_inv;
  logic                 track_hit;

  logic [FS_CNT_W-1:0]  len_eff;
  logic                 wrap;
  logic [2:0]           chk_eff;
  logic                 chk_reached;
  logic [3:0]           miss_next;
  logic                 fly_exceeded;

  assign state = state_q;

  sync_correlator #(
    .SYNC_WIDTH (SYNC_WIDTH),
    .ERR_W      (ERR_W)
  ) u_corr_true (
    .clk     (clk),
    .reset_n (reset_n),
    .bit_en  (bitEn),
    .bit_in  (bitIn),
    .pattern (syncPattern),
    .mask    (syncMask),
    .errors  (err_true)
  );

`ifdef PCM_FRAME_SYNC_INVERT_EN
  logic [ERR_W-1:0] err_inv;

  sync_correlator #(
    .SYNC_WIDTH (SYNC_WIDTH),
    .ERR_W      (ERR_W)
  ) u_corr_inv (
    .clk     (clk),
    .reset_n (reset_n),
    .bit_en  (bitEn),
    .bit_in  (bitIn),
    .pattern (~syncPattern),
    .mask    (syncMask),
    .errors  (err_inv)
  );

  // Polarity selection: a true match always beats an inverted one, and once inverted the tracking states follow the complemented pattern.
  always_comb begin
    true_hit   = int'(err_true) <= int'(searchTol);
    inv_hit    = int'(err_inv) <= int'(searchTol);
    search_err = (!true_hit && inv_hit) ? err_inv : err_true;
    err_track  = inverted ? err_inv : err_true;
  end
`else
  // Single-polarity build: only the true correlator exists.
  always_comb begin
    true_hit   = int'(err_true) <= int'(searchTol);
    inv_hit    = 1'b0;
    search_err = err_true;
    err_track  = err_true;
  end
`endif

  // Frame geometry and threshold decisions shared by every state.
  always_comb begin
    len_eff      = fs_eff_length(frameLength, SYNC_WIDTH);
    wrap         = (bitCount == (len_eff - 16'd1));
    search_hit   = true_hit || inv_hit;
    set_inv      = (state_q == FS_SEARCH) && !true_hit && inv_hit;
    track_hit    = int'(err_track) <= int'(lockTol);
    chk_eff      = (checkFrames == 3'd0) ? 3'd1 : checkFrames;
    chk_reached  = ({1'b0, hit_cnt} + 4'd1) >= {1'b0, chk_eff};
    miss_next    = miss_cnt + 4'd1;
    fly_exceeded = miss_next > {1'b0, flyFrames};
  end

  // Frame sync state machine with all outputs registered on the bit-strobe edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FS_SEARCH;
      bitOut     <= 1'b0;
      bitEnOut   <= 1'b0;
      frameStart <= 1'b0;
      bitCount   <= '0;
      locked     <= 1'b0;
      errCount   <= '0;
      inverted   <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      bitEnOut   <= bitEn;
      frameStart <= 1'b0;
      if (resync) begin
        if (bitEn) begin
          bitOut <= bitIn;
        end
        state_q  <= FS_SEARCH;
        bitCount <= '0;
        hit_cnt  <= '0;
        miss_cnt <= '0;
        locked   <= 1'b0;
        errCount <= '0;
        inverted <= 1'b0;
      end else if (bitEn) begin
        bitOut   <= bitIn ^ (inverted | set_inv);
        bitCount <= wrap ? '0 : bitCount + 16'd1;
        case (state_q)
          FS_SEARCH: begin
            errCount <= search_err;
            if (search_hit) begin
              state_q    <= FS_CHECK;
              bitCount   <= '0;
              hit_cnt    <= '0;
              frameStart <= 1'b1;
              inverted   <= set_inv;
            end
          end
          FS_CHECK: begin
            if (wrap) begin
              errCount <= err_track;
              if (track_hit) begin
                frameStart <= 1'b1;
                if (chk_reached) begin
                  state_q <= FS_LOCK;
                  locked  <= 1'b1;
                  hit_cnt <= '0;
                end else begin
                  hit_cnt <= hit_cnt + 3'd1;
                end
              end else begin
                state_q  <= FS_SEARCH;
                hit_cnt  <= '0;
                inverted <= 1'b0;
              end
            end
          end
          FS_LOCK: begin
            if (wrap) begin
              errCount <= err_track;
              if (track_hit) begin
                frameStart <= 1'b1;
              end else if (flyFrames == 3'd0) begin
                state_q  <= FS_SEARCH;
                locked   <= 1'b0;
                inverted <= 1'b0;
              end else begin
                state_q    <= FS_FLYWHEEL;
                miss_cnt   <= 4'd1;
                frameStart <= 1'b1;
              end
            end
          end
          FS_FLYWHEEL: begin
            if (wrap) begin
              errCount <= err_track;
              if (track_hit) begin
                state_q    <= FS_LOCK;
                miss_cnt   <= '0;
                frameStart <= 1'b1;
              end else if (fly_exceeded) begin
                state_q  <= FS_SEARCH;
                miss_cnt <= '0;
                locked   <= 1'b0;
                inverted <= 1'b0;
              end else begin
                miss_cnt   <= miss_next;
                frameStart <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= FS_SEARCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_sync.sv
// tb_pcm_frame_sync: directed bench for pcm_frame_sync (SYNC_WIDTH = 32).
// Expectations follow PCM_FRAME_SYNC_INVERT_EN when it is defined.
module tb_pcm_frame_sync;
  import pcm_frame_sync_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        bitEn;
  logic        bitIn;
  logic        resync;
  logic [31:0] syncPattern;
  logic [31:0] syncMask;
  logic [15:0] frameLength;
  logic [3:0]  searchTol;
  logic [3:0]  lockTol;
  logic [2:0]  checkFrames;
  logic [2:0]  flyFrames;
  logic        bitOut;
  logic        bitEnOut;
  logic        frameStart;
  logic [15:0] bitCount;
  logic [1:0]  state;
  logic        locked;
  logic [5:0]  errCount;
  logic        inverted;

  int assertCount = 0;
  int failCount   = 0;

  int obsFs, obsCount, obsState, obsErr, obsLocked, obsBitEnOut, obsInv;
  int preSyncCount;
  int extraFs;
  int bitOutErrs = 0;
  logic invertStream = 1'b0;
  logic bitOutCheck  = 1'b1;
  logic bitOutTrue   = 1'b0;

  localparam logic [31:0] ERR2 = 32'h0000_0021;
  localparam logic [31:0] ERR3 = 32'h0000_0007;

  pcm_frame_sync dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bitEn       (bitEn),
    .bitIn       (bitIn),
    .resync      (resync),
    .syncPattern (syncPattern),
    .syncMask    (syncMask),
    .frameLength (frameLength),
    .searchTol   (searchTol),
    .lockTol     (lockTol),
    .checkFrames (checkFrames),
    .flyFrames   (flyFrames),
    .bitOut      (bitOut),
    .bitEnOut    (bitEnOut),
    .frameStart  (frameStart),
    .bitCount    (bitCount),
    .state       (state),
    .locked      (locked),
    .errCount    (errCount),
    .inverted    (inverted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One bit strobe; outputs captured 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic b, input logic rs);
    logic phys;
    phys = b ^ invertStream;
    @(negedge clk);
    bitEn  = 1'b1;
    bitIn  = phys;
    resync = rs;
    @(posedge clk);
    #1;
    obsFs       = int'(frameStart);
    obsCount    = int'(bitCount);
    obsState    = int'(state);
    obsErr      = int'(errCount);
    obsLocked   = int'(locked);
    obsBitEnOut = int'(bitEnOut);
    obsInv      = int'(inverted);
    if (bitOutCheck && (bitOut !== (bitOutTrue ? b : phys))) bitOutErrs++;
    @(negedge clk);
    bitEn  = 1'b0;
    resync = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendSync(input logic [31:0] word, input logic rsLast);
    for (int i = 31; i >= 0; i--) begin
      applyStimulus(word[i], (i == 0) ? rsLast : 1'b0);
      if (i == 1) preSyncCount = obsCount;
    end
  endtask

  task automatic sendPayload(input int n);
    extraFs = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      extraFs += obsFs;
    end
  endtask

  task automatic pulseResync();
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b1;
    bitEn       = 1'b0;
    bitIn       = 1'b0;
    resync      = 1'b0;
    syncPattern = FS_DEFAULT_SYNC;
    syncMask    = 32'hFFFF_FFFF;
    frameLength = 16'd256;
    searchTol   = 4'd0;
    lockTol     = 4'd2;
    checkFrames = 3'd2;
    flyFrames   = 3'd2;

    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_outs", int'({bitOut, bitEnOut, frameStart, locked, inverted, errCount, bitCount}), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Acquisition: SEARCH -> CHECK -> CHECK -> LOCK on the third sync word.
    sendPayload(40);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("acq1_state", obsState, int'(FS_CHECK));
    checkOutput("acq1_fs", obsFs, 1);
    checkOutput("acq1_count", obsCount, 0);
    checkOutput("acq1_err", obsErr, 0);
    checkOutput("acq1_fs_with_en", obsBitEnOut, 1);
    sendPayload(224);
    checkOutput("acq1_payload_fs", extraFs, 0);
    checkOutput("acq1_end_count", obsCount, 224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("acq2_precount", preSyncCount, 255);
    checkOutput("acq2_state", obsState, int'(FS_CHECK));
    checkOutput("acq2_fs", obsFs, 1);
    checkOutput("acq2_locked", obsLocked, 0);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("acq3_state", obsState, int'(FS_LOCK));
    checkOutput("acq3_locked", obsLocked, 1);
    checkOutput("acq3_count", obsCount, 0);

    // Error tolerance while locked, flywheel and loss of lock.
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC ^ ERR2, 1'b0);
    checkOutput("err2_state", obsState, int'(FS_LOCK));
    checkOutput("err2_err", obsErr, 2);
    checkOutput("err2_fs", obsFs, 1);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC ^ ERR3, 1'b0);
    checkOutput("miss1_state", obsState, int'(FS_FLYWHEEL));
    checkOutput("miss1_err", obsErr, 3);
    checkOutput("miss1_fs", obsFs, 1);
    checkOutput("miss1_locked", obsLocked, 1);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("fly_recover_state", obsState, int'(FS_LOCK));
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC ^ ERR3, 1'b0);
    checkOutput("missA_state", obsState, int'(FS_FLYWHEEL));
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC ^ ERR3, 1'b0);
    checkOutput("missB_state", obsState, int'(FS_FLYWHEEL));
    checkOutput("missB_fs", obsFs, 1);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC ^ ERR3, 1'b0);
    checkOutput("missC_state", obsState, int'(FS_SEARCH));
    checkOutput("missC_locked", obsLocked, 0);

    // Sync word one bit early while in CHECK.
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("short_first_state", obsState, int'(FS_CHECK));
    sendPayload(223);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("short_sync_count", obsCount, 255);
    checkOutput("short_sync_fs", obsFs, 0);
    checkOutput("short_sync_state", obsState, int'(FS_CHECK));
    sendPayload(1);
    checkOutput("short_wrap_state", obsState, int'(FS_SEARCH));
    sendPayload(223);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("short_reacq_state", obsState, int'(FS_CHECK));
    checkOutput("short_reacq_locked", obsLocked, 0);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("short_relock_state", obsState, int'(FS_LOCK));

    // Asynchronous reset in the middle of a locked frame.
    sendPayload(100);
    checkOutput("pre_reset_count", obsCount, 100);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_state", int'(state), 0);
    checkOutput("mid_reset_outs", int'({bitOut, bitEnOut, frameStart, locked, inverted, errCount, bitCount}), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    sendPayload(60);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("rlk1_state", obsState, int'(FS_CHECK));
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("rlk2_state", obsState, int'(FS_CHECK));
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("rlk3_state", obsState, int'(FS_LOCK));

    // resync on the same strobe as a good sync word.
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b1);
    checkOutput("resync_state", obsState, int'(FS_SEARCH));
    checkOutput("resync_fs", obsFs, 0);
    checkOutput("resync_count", obsCount, 0);
    checkOutput("resync_locked", obsLocked, 0);

    // frameLength below the minimum behaves as 33 bits.
    frameLength = 16'd10;
    pulseResync();
    sendPayload(20);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("fl_s1_state", obsState, int'(FS_CHECK));
    sendPayload(1);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("fl_s2_precount", preSyncCount, 32);
    checkOutput("fl_s2_fs", obsFs, 1);
    checkOutput("fl_s2_state", obsState, int'(FS_CHECK));
    sendPayload(1);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    checkOutput("fl_s3_state", obsState, int'(FS_LOCK));

    checkOutput("bitout_plain", bitOutErrs, 0);

    // Inverted stream.
    frameLength  = 16'd256;
    pulseResync();
    invertStream = 1'b1;
    bitOutCheck  = 1'b0;
    bitOutErrs   = 0;
    sendPayload(40);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
`ifdef PCM_FRAME_SYNC_INVERT_EN
    checkOutput("inv1_state", obsState, int'(FS_CHECK));
    checkOutput("inv1_flag", obsInv, 1);
    bitOutTrue = 1'b1;
`else
    checkOutput("inv1_state", obsState, int'(FS_SEARCH));
    checkOutput("inv1_flag", obsInv, 0);
    bitOutTrue = 1'b0;
`endif
    bitOutCheck = 1'b1;
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
    sendPayload(224);
    sendSync(FS_DEFAULT_SYNC, 1'b0);
`ifdef PCM_FRAME_SYNC_INVERT_EN
    checkOutput("inv3_state", obsState, int'(FS_LOCK));
    checkOutput("inv3_flag", obsInv, 1);
`else
    checkOutput("inv3_state", obsState, int'(FS_SEARCH));
    checkOutput("inv3_flag", obsInv, 0);
`endif
    checkOutput("bitout_inv", bitOutErrs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pcm_frame_sync.md
# pcm_frame_sync

Frame synchronizer that sits directly downstream of the PCM decoder and consumes its NRZ-L bit stream and bit enable. It correlates a programmable sync word against the incoming bits and tracks frame position with a SEARCH/CHECK/LOCK/FLYWHEEL state machine. It outputs a frame-aligned bit stream, a frame-start strobe, a bit position counter and lock status to the downstream word/frame formatter.

## Interface
- SYNC_WIDTH, 32: sync word length in bits, 8..32; the error count width is clog2(SYNC_WIDTH+1).
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- bitEn  in  1  one-clk bit strobe, NRZ-L rate; successive strobes at least 2 clk apart
- bitIn  in  1  decoded bit, valid when bitEn is high
- resync  in  1  synchronous pulse that forces SEARCH
- syncPattern  in  SYNC_WIDTH  sync word; MSB is received first
- syncMask  in  SYNC_WIDTH  1 = bit participates in correlation
- frameLength  in  16  bits per frame, sync included; values below SYNC_WIDTH+1 are treated as SYNC_WIDTH+1
- searchTol  in  4  maximum bit errors accepted in SEARCH
- lockTol  in  4  maximum bit errors accepted in CHECK, LOCK and FLYWHEEL
- checkFrames  in  3  consecutive hits needed in CHECK; 0 behaves as 1
- flyFrames  in  3  consecutive misses tolerated before SEARCH; 0 means the first miss returns to SEARCH
- bitOut  out  1  registered copy of bitIn; polarity-corrected when inversion is enabled
- bitEnOut  out  1  bitEn delayed 1 clk
- frameStart  out  1  1-clk pulse marking the last sync bit of an accepted frame
- bitCount  out  16  frame position of bitOut; 0 = last sync bit
- state  out  2  0 SEARCH, 1 CHECK, 2 LOCK, 3 FLYWHEEL
- locked  out  1  high in LOCK or FLYWHEEL
- errCount  out  clog2(SYNC_WIDTH+1)  error count of the most recent evaluation
- inverted  out  1  inverted polarity detected (always 0 unless inversion is enabled)

## Operation
- On each bitEn, the shift register becomes sr_next = {sr[SYNC_WIDTH-2:0], bitIn}.
- errors = popcount((sr_next ^ syncPattern) & syncMask), computed combinationally within the same cycle.
- bitCount increments on each bitEn and wraps to 0 after frameLength-1. An evaluation occurs on the bitEn that makes bitCount wrap to 0.
- SEARCH: every bitEn is evaluated.
  - If errors <= searchTol, go to CHECK, set bitCount=0, clear the hit counter and pulse frameStart.
- CHECK: evaluate only at the wrap point; matches elsewhere are ignored.
  - A hit (errors <= lockTol) increments the hit counter and pulses frameStart. Reaching checkFrames hits moves to LOCK.
  - A miss returns to SEARCH.
- LOCK: at the wrap point, a hit pulses frameStart. A miss moves to FLYWHEEL, sets the miss counter to 1 and still pulses frameStart.
- FLYWHEEL: at the wrap point, a hit returns to LOCK with the miss counter cleared. A miss increments the miss counter; when the counter exceeds flyFrames, go to SEARCH.
- If a miss occurs in LOCK with flyFrames=0, go directly to SEARCH.
- resync wins over a simultaneous bitEn: state goes to SEARCH, counters clear and no frameStart is issued.
- Changing configuration inputs outside SEARCH has undefined results; software must pulse resync after any change.

## Timing
- Latency is 1 clk: bitOut, bitEnOut, frameStart, bitCount, state and errCount update on the clk edge at which bitEn is sampled high.
- frameStart coincides with bitEnOut.
- reset_n low: all outputs are 0 and state=SEARCH. Shift register, counters and inverted clear asynchronously; this applies mid-frame as well.
- After a match is found, LOCK is reached checkFrames × frameLength bits after the initial SEARCH hit.

## Configuration
- PCM_FRAME_SYNC_INVERT_EN defined:
  - A second correlator tests ~syncPattern.
  - In SEARCH, an inverted match with no true match sets inverted=1. Once set, bitOut is inverted and all later evaluations use the inverted pattern, until the block returns to SEARCH, which clears inverted.
  - If true and inverted matches occur on the same bit, the true match wins.
- Not defined: there is a single correlator and inverted is tied to 0.

## Structure
- Shared package pcm_frame_sync_pkg holds:
  - state encodings (FS_SEARCH, FS_CHECK, FS_LOCK, FS_FLYWHEEL)
  - the 16-bit frame counter width
  - default SYNC_WIDTH
  - the standard 32-bit pattern constant FS_DEFAULT_SYNC = 32'hFE6B2840.
- Sub-module sync_correlator: shift register plus masked popcount. It is instantiated twice when PCM_FRAME_SYNC_INVERT_EN is defined.

## Test plan
- Frames of 256 bits using pattern FE6B2840, full mask, searchTol=0, lockTol=2, checkFrames=2, random payload -> state goes SEARCH→CHECK→LOCK; LOCK is entered on the 3rd sync word; frameStart every 256 bitEnOut; bitCount=0 at each pulse.
- While locked, inject 2 bit errors into one sync word -> stays LOCK; errCount=2. Inject 3 errors -> FLYWHEEL. With flyFrames=2, two more bad words -> SEARCH after the 3rd consecutive miss; frameStart continues through the misses.
- After reaching CHECK, the next sync word is placed at 255 bits instead of 256 -> returns to SEARCH; no LOCK.
- reset_n pulsed low mid-frame while in LOCK -> all outputs 0 immediately; relock requires the full CHECK sequence. resync asserted on the same clk as bitEn -> SEARCH, no frameStart.
- With the macro defined, feed an inverted stream -> inverted=1; bitOut equals the true data; LOCK is reached. With the macro undefined, the same stream stays in SEARCH.
- frameLength=10 with SYNC_WIDTH=32 -> frame period behaves as 33 bits.
